// File: rtl/cache_way_mux_pipe.sv
// cache_way_mux_pipe
// Two-stage valid/ready way selector for the cache read path. Picks one
// WIDTH-bit lane out of WAYS lanes, steered by a binary index (SEL_MODE=0)
// or a one-hot tag-hit vector (SEL_MODE=1), and counts multi-hit beats.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   way_data              WAYS lanes, lane i at [i*WIDTH +: WIDTH]
//   sel                   binary way index (SEL_MODE=0)
//   hit_vec               tag-hit vector (SEL_MODE=1)
//   out_valid / out_ready output beat handshake
//   out_data, out_way     selected lane data and its index
//   out_hit               a legal lane was selected
//   out_multihit          more than one hit_vec bit set
//   err_count             saturating count of delivered multi-hit beats

// One lane of the AND-OR mux: passes its data only when it is the selected lane.
module cache_way_lane #(
    parameter int WIDTH = 32,
    parameter int SELW  = 3,
    parameter int LANE  = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SELW-1:0]  idx,
    input  logic             hit,
    output logic [WIDTH-1:0] masked
);
    assign masked = (hit && (idx == SELW'(LANE))) ? data : '0;
endmodule

module cache_way_mux_pipe #(
    parameter int WAYS     = 8,
    parameter int WIDTH    = 32,
    parameter int SEL_MODE = 0,
    parameter int CNTW     = 16,
    localparam int SELW    = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WAYS*WIDTH-1:0] way_data,
    input  logic [SELW-1:0]       sel,
    input  logic [WAYS-1:0]       hit_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_way,
    output logic                  out_hit,
    output logic                  out_multihit,
    output logic [CNTW-1:0]       err_count
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [SELW-1:0] idx;
        logic            hit;
        logic            mh;
    } dec_t;

    logic [STAGES:1]              vld_pipe;
    logic                         s2_free;
    logic                         s1_adv;
    dec_t                         dec_in;
    dec_t                         s1_dec;
    logic [WAYS-1:0][WIDTH-1:0]   s1_data;
    logic [WAYS-1:0][WIDTH-1:0]   lane_q;
    logic [WIDTH-1:0]             mux_data;

    // Only one of sel / hit_vec is meaningful for a given SEL_MODE.
    logic unused_sel;
    assign unused_sel = ^{sel, hit_vec};

    assign s2_free   = !vld_pipe[2] || out_ready;
    assign s1_adv    = vld_pipe[1] && s2_free;
    // Combinational from out_ready so a full pipe keeps streaming at 1 beat/cycle.
    assign in_ready  = !vld_pipe[1] || s2_free;
    assign out_valid = vld_pipe[2];

    // Index decode happens ahead of S1 so S2 only has the lane mux in its path.
    always_comb begin
        dec_in = '0;
        if (SEL_MODE == 0) begin
            dec_in.idx = sel;
            dec_in.hit = ({1'b0, sel} < (SELW+1)'(WAYS));
        end else begin
            dec_in.hit = |hit_vec;
            // Clearing the lowest set bit leaves something only on a multi-hit.
            dec_in.mh  = |(hit_vec & (hit_vec - WAYS'(1)));
            // Descending scan so the lowest set bit wins.
            for (int i = WAYS-1; i >= 0; i--) begin
                if (hit_vec[i]) dec_in.idx = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (s2_free)  vld_pipe[2] <= vld_pipe[1];
        end
    end

    // S1 payload carries no reset; it is qualified by vld_pipe[1].
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_data <= way_data;
            s1_dec  <= dec_in;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_lane
        cache_way_lane #(
            .WIDTH (WIDTH),
            .SELW  (SELW),
            .LANE  (g)
        ) u_lane (
            .data   (s1_data[g]),
            .idx    (s1_dec.idx),
            .hit    (s1_dec.hit),
            .masked (lane_q[g])
        );
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < WAYS; i++) mux_data |= lane_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data     <= '0;
            out_way      <= '0;
            out_hit      <= 1'b0;
            out_multihit <= 1'b0;
            err_count    <= '0;
        end else begin
            if (s1_adv) begin
                out_data     <= mux_data;
                out_way      <= s1_dec.idx;
                out_hit      <= s1_dec.hit;
                out_multihit <= s1_dec.mh;
            end
            // Counted on delivery, not on entry, so stalled beats count once.
            if (out_valid && out_ready && out_multihit && (err_count != '1))
                err_count <= err_count + CNTW'(1);
        end
    end
endmodule

// File: doc/cache_way_mux_pipe.md
Name: cache_way_mux_pipe

Overview:
Parametrised, pipelined N-way data selector for the cache read path. It picks one WIDTH-bit word out of WAYS way-data lanes, using either a binary way index or a one-hot tag-hit vector. It uses a 2-stage valid/ready pipeline and flags multi-hit errors, keeping a saturating count of them. It sits between the tag/data array read and the cache response port.

Parameters:
WAYS, 8, number of way lanes (2..32, need not be a power of 2)
WIDTH, 32, bits per way lane
SEL_MODE, 0, 0 = binary index select on sel; 1 = one-hot select on hit_vec
SELW, $clog2(WAYS), derived localparam, width of the way index
CNTW, 16, width of the multi-hit error counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  pipeline can accept a beat this cycle
way_data  input  WAYS*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
sel  input  SELW  binary way index (used when SEL_MODE=0)
hit_vec  input  WAYS  one-hot hit vector (used when SEL_MODE=1)
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the output beat
out_data  output  WIDTH  selected lane data
out_way  output  SELW  index of the selected lane
out_hit  output  1  a legal lane was selected
out_multihit  output  1  more than one hit_vec bit was set (SEL_MODE=1 only)
err_count  output  CNTW  saturating count of multi-hit beats delivered

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_way=0, out_hit=0, out_multihit=0, err_count=0. In-flight beats are discarded, including during a reset asserted mid-stream.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. out_valid is held, and out_data/out_way/out_hit/out_multihit stay stable, until out_ready. out_valid never depends combinationally on out_ready.
- Stage 1 (S1) registers way_data plus the decoded index, hit and multihit.
- Stage 2 (S2) registers the mux result into the out_* registers.
- s2_free = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_free.
- in_ready = !s1_valid || s2_free. This is a combinational path from out_ready, by design.
- Latency: an accepted beat appears on out_valid 2 cycles later with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Decode, SEL_MODE=0:
  - idx = sel, hit = (sel < WAYS), multihit = 0.
  - sel >= WAYS: out_hit=0, out_data=0, out_way=sel.
- Decode, SEL_MODE=1:
  - idx = lowest set bit of hit_vec, hit = |hit_vec, multihit = more than one bit set.
  - hit_vec = 0: out_hit=0, out_data=0, out_way=0.
  - Multi-hit: data comes from the lowest-index hit lane, and out_hit=1.
- err_count increments by 1 on each output transfer with out_multihit=1. It saturates at all-ones, with no wrap. It is cleared by reset only.
- Simultaneous accept of S1 into S2 and of a new input into S1 in the same cycle is legal, with no bubble inserted.
- While stalled (out_ready=0, both stages full), in_ready=0 and inputs are ignored.

Test Plan:
- SEL_MODE=0, WAYS=8, WIDTH=32, lane i = 0xA0+i, sel=5, out_ready=1 -> 2 cycles later out_valid=1, out_data=0xA5, out_way=5, out_hit=1, out_multihit=0.
- SEL_MODE=0, WAYS=6, sel=7 -> out_hit=0, out_data=0, out_way=7. Then sel=0..5 streamed back-to-back -> 6 consecutive out beats with data 0xA0..0xA5 and no gaps.
- SEL_MODE=1, hit_vec=8'b0010_1000 -> out_way=3, out_data=0xA3, out_hit=1, out_multihit=1, err_count goes 0 -> 1 on the transfer. hit_vec=0 -> out_hit=0, out_data=0.
- Backpressure: stream 4 beats while out_ready is held 0 for 5 cycles -> in_ready drops after 2 beats are accepted, out_data stays stable. Release out_ready -> all 4 beats delivered in order, none lost or duplicated.
- CNTW=4, 20 multi-hit beats -> err_count reads 15 after beat 15 and stays at 15 through beat 20.
- Assert reset with both stages full -> out_valid=0 and err_count=0 immediately (async). After release, in_ready=1, and the first new beat emerges after 2 cycles.
